// File: rtl/lc3_mem_ctrl.sv
// Unified single-port memory controller and backing store for the LC-3 core.
// Optional access statistics ports are enabled by defining LC3_MEM_STATS_EN.
module lc3_mem_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        I_macc,
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  input  logic        D_macc,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Instr_dout,
  output logic [15:0] Data_dout,
  output logic        complete_instr,
  output logic        complete_data
`ifdef LC3_MEM_STATS_EN
  ,
  output logic [15:0] i_count,
  output logic [15:0] d_count,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_rd;
  logic [15:0]         lat_din;
  logic [15:0]         mem [DEPTH];
  logic                mem_we_c;
  logic                unused_addr_hi;

  // Upper address bits are intentionally ignored: addresses alias modulo DEPTH.
  assign unused_addr_hi = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};

  // Access FSM: accept (data first), count down the latency, execute, then one DONE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (D_macc) begin
            lat_addr <= Data_addr[ADDR_W-1:0];
            lat_rd   <= Data_rd;
            lat_din  <= Data_din;
            cnt      <= CNT_W'(LATENCY - 1);
            state    <= BUSY_D;
          end else if (I_macc && instrmem_rd) begin
            lat_addr <= pc[ADDR_W-1:0];
            cnt      <= CNT_W'(LATENCY - 1);
            state    <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (cnt == '0) begin
            if (lat_rd) Data_dout <= mem[lat_addr];
            complete_data <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BUSY_I: begin
          if (cnt == '0) begin
            Instr_dout     <= mem[lat_addr];
            complete_instr <= 1'b1;
            state          <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset suppresses the write so an abandoned store never lands in memory.
  assign mem_we_c = !reset && (state == BUSY_D) && (cnt == '0) && !lat_rd;

  always_ff @(posedge clock) begin
    if (mem_we_c) mem[lat_addr] <= lat_din;
  end

`ifdef LC3_MEM_STATS_EN
  // Completion and fetch-stall counters; all wrap naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_count     <= '0;
      d_count     <= '0;
      stall_count <= '0;
    end else begin
      if (state == BUSY_I && cnt == '0) i_count <= i_count + 16'd1;
      if (state == BUSY_D && cnt == '0) d_count <= d_count + 16'd1;
      if (I_macc && state != BUSY_I && !complete_instr) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: transaction-schedule reference model,
// per-cycle output comparison, directed scenarios and randomized concurrent traffic.
module tb_lc3_mem_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        I_macc = 1'b0, instrmem_rd = 1'b0, D_macc = 1'b0, Data_rd = 1'b0;
  logic [15:0] pc = '0, Data_addr = '0, Data_din = '0;
  logic [15:0] Instr_dout, Data_dout;
  logic        complete_instr, complete_data;
`ifdef LC3_MEM_STATS_EN
  logic [15:0] i_count, d_count, stall_count;
`endif

  lc3_mem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .I_macc(I_macc), .instrmem_rd(instrmem_rd), .pc(pc),
    .D_macc(D_macc), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Instr_dout(Instr_dout), .Data_dout(Data_dout),
    .complete_instr(complete_instr), .complete_data(complete_data)
`ifdef LC3_MEM_STATS_EN
    , .i_count(i_count), .d_count(d_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one outstanding access, completion scheduled LAT cycles after acceptance.
  logic [15:0] mm [DEPTH];
  bit          armed = 0, pend = 0, pend_d = 0, pend_rd = 0;
  int unsigned pend_addr = 0, comp_cyc = 0, free_cyc = 0, k = 0;
  logic [15:0] pend_din = '0, e_idout = '0, e_ddout = '0;
  logic [15:0] e_ic = '0, e_dc = '0, e_sc = '0;
  bit          e_ci = 0, e_cd = 0;

  always @(negedge clock) begin
    k = cyc;
    e_ci = 0;
    e_cd = 0;
    if (pend && comp_cyc == k) begin
      pend = 0;
      if (pend_d) begin
        e_cd = 1;
        e_dc = e_dc + 16'd1;
        if (pend_rd) e_ddout = mm[pend_addr];
        else mm[pend_addr] = pend_din;
      end else begin
        e_ci = 1;
        e_ic = e_ic + 16'd1;
        e_idout = mm[pend_addr];
      end
    end
    if (armed) begin
      chk("complete_instr", 16'(complete_instr), 16'(e_ci));
      chk("complete_data", 16'(complete_data), 16'(e_cd));
      chk("Instr_dout", Instr_dout, e_idout);
      chk("Data_dout", Data_dout, e_ddout);
      chk("complete_exclusive", 16'(complete_instr & complete_data), 16'h0000);
`ifdef LC3_MEM_STATS_EN
      chk("i_count", i_count, e_ic);
      chk("d_count", d_count, e_dc);
      chk("stall_count", stall_count, e_sc);
`endif
      if (I_macc && !(pend && !pend_d) && !e_ci) e_sc = e_sc + 16'd1;
    end
    if (reset) begin
      pend = 0;
      e_idout = '0;
      e_ddout = '0;
      e_ic = '0;
      e_dc = '0;
      e_sc = '0;
      free_cyc = k + 1;
      armed = 1;
    end else if (armed && !pend && k >= free_cyc) begin
      if (D_macc) begin
        pend = 1; pend_d = 1; pend_rd = Data_rd;
        pend_addr = int'(Data_addr) % DEPTH;
        pend_din = Data_din;
        comp_cyc = k + 1 + LAT;
        free_cyc = k + 2 + LAT;
      end else if (I_macc && instrmem_rd) begin
        pend = 1; pend_d = 0;
        pend_addr = int'(pc) % DEPTH;
        comp_cyc = k + 1 + LAT;
        free_cyc = k + 2 + LAT;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic fetch(input logic [15:0] a, input bit scr,
                       output int unsigned done_cyc, output int unsigned lat);
    int unsigned start, n;
    I_macc = 1'b1; instrmem_rd = 1'b1; pc = a;
    start = cyc; n = 0;
    while (!complete_instr && n < 100) begin
      tick(1);
      n++;
      if (scr) pc = 16'($urandom);
    end
    if (!complete_instr) begin
      tests++; fails++;
      $display("FAIL fetch_timeout cyc=%0d actual=no_complete required=complete", cyc);
    end
    done_cyc = cyc;
    lat = cyc - start;
    I_macc = 1'b0;
    tick(1);
  endtask

  task automatic data_op(input bit rd, input logic [15:0] a, input logic [15:0] d, input bit scr,
                         output int unsigned done_cyc, output int unsigned lat);
    int unsigned start, n;
    D_macc = 1'b1; Data_rd = rd; Data_addr = a; Data_din = d;
    start = cyc; n = 0;
    while (!complete_data && n < 100) begin
      tick(1);
      n++;
      if (scr) begin
        Data_addr = 16'($urandom);
        Data_din  = 16'($urandom);
      end
    end
    if (!complete_data) begin
      tests++; fails++;
      $display("FAIL data_timeout cyc=%0d actual=no_complete required=complete", cyc);
    end
    done_cyc = cyc;
    lat = cyc - start;
    D_macc = 1'b0;
    tick(1);
  endtask

  function automatic logic [15:0] win_addr();
    return {6'($urandom), 4'b0000, 6'($urandom)};
  endfunction

  int unsigned dc, ic, lt, lt2;
  logic [15:0] hold;

  initial begin
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("reset_Data_dout", Data_dout, 16'h0000);
    chk("reset_Instr_dout", Instr_dout, 16'h0000);

    // Fill the 64-word working window so every later read is defined.
    for (int i = 0; i < 64; i++) data_op(1'b0, 16'(i), 16'($urandom), 1'b0, dc, lt);

    // Preloaded instruction fetch with latency measurement.
    data_op(1'b0, 16'h3000, 16'h1261, 1'b0, dc, lt);
    fetch(16'h3000, 1'b0, ic, lt);
    chk("fetch_latency", 16'(lt - 1), 16'(LAT));
    chk("fetch_3000", Instr_dout, 16'h1261);
    chk("done_no_pulse", 16'(complete_instr), 16'h0000);

    // Write then read back; the write leaves Data_dout alone.
    hold = Data_dout;
    data_op(1'b0, 16'h0040, 16'hBEEF, 1'b1, dc, lt);
    chk("write_keeps_dout", Data_dout, hold);
    data_op(1'b1, 16'h0040, 16'h0000, 1'b1, dc, lt);
    chk("read_0040", Data_dout, 16'hBEEF);

    // Address aliasing modulo 2^ADDR_W.
    data_op(1'b0, 16'h0405, 16'h1234, 1'b0, dc, lt);
    data_op(1'b1, 16'h0005, 16'h0000, 1'b0, dc, lt);
    chk("alias_0005", Data_dout, 16'h1234);

    // Simultaneous requests: data first, instruction LAT+2 cycles later.
    fork
      fetch(16'h0040, 1'b0, ic, lt);
      data_op(1'b1, 16'h3000, 16'h0000, 1'b0, dc, lt2);
    join
    chk("i_after_d", 16'(ic - dc), 16'(LAT + 2));
    chk("simul_instr", Instr_dout, 16'hBEEF);
    chk("simul_data", Data_dout, 16'h1261);

    // A fetch request without the read strobe is never accepted.
    I_macc = 1'b1; instrmem_rd = 1'b0; pc = 16'h0005;
    tick(6);
    chk("no_strobe_no_fetch", 16'(complete_instr), 16'h0000);
    I_macc = 1'b0;
    tick(1);

    // Reset while a write is in flight abandons it.
    data_op(1'b0, 16'h0010, 16'hA5A5, 1'b0, dc, lt);
    D_macc = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0010; Data_din = 16'h5555;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0; D_macc = 1'b0;
    chk("rst_complete_data", 16'(complete_data), 16'h0000);
    chk("rst_Data_dout", Data_dout, 16'h0000);
    chk("rst_Instr_dout", Instr_dout, 16'h0000);
    tick(4);
    data_op(1'b1, 16'h0010, 16'h0000, 1'b0, dc, lt);
    chk("rst_write_dropped", Data_dout, 16'hA5A5);

`ifdef LC3_MEM_STATS_EN
    // Three fetches and one load, the first fetch blocked behind the load.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    fork
      fetch(16'h0001, 1'b0, ic, lt);
      data_op(1'b1, 16'h0002, 16'h0000, 1'b0, dc, lt2);
    join
    fetch(16'h0003, 1'b0, ic, lt);
    fetch(16'h0004, 1'b0, ic, lt);
    chk("stats_i_count", i_count, 16'd3);
    chk("stats_d_count", d_count, 16'd1);
    chk("stats_stall_count", stall_count, 16'(LAT + 3 + 2));
`endif

    // Randomized concurrent traffic with inputs scrambled while waiting.
    fork
      begin
        int unsigned c1, l1;
        for (int i = 0; i < 30; i++) begin
          tick($urandom_range(0, 3));
          fetch(win_addr(), 1'b1, c1, l1);
        end
      end
      begin
        int unsigned c2, l2;
        for (int j = 0; j < 30; j++) begin
          tick($urandom_range(0, 3));
          data_op(1'($urandom), win_addr(), 16'($urandom), 1'b1, c2, l2);
        end
      end
    join
    tick(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++; fails++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
